dot_seq: RTL

DOT_SEQ -- requirements
Module: dot_seq

---
 rtl/kmed_pkg.sv | 15 +
 rtl/dot_acc.sv | 53 +++++
 rtl/dot_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/kmed_pkg.sv
// Shared definitions for the dot-product / L1-distance sequencer:
// FSM state encoding and default widths.
package kmed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 36;
  localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/dot_acc.sv
// Accumulate datapath: per-beat term (product, or |a-b| when DOT_SEQ_L1_EN
// is defined) added into an ACC_W-bit register with a sticky carry-out flag.
module dot_acc
  import kmed_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  function automatic logic [2*DATA_W-1:0] term(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
`ifdef DOT_SEQ_L1_EN
    logic [DATA_W-1:0] d;
    d = (x >= y) ? (x - y) : (y - x);
    return {{DATA_W{1'b0}}, d};
`else
    return {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
`endif
  endfunction

  logic [2*DATA_W-1:0] term_p0;
  logic [ACC_W:0]      sum_p0;

  // Stage 0: term and widened add; bit ACC_W is the carry out.
  always_comb begin
    term_p0 = term(a, b);
    sum_p0  = {1'b0, acc} + (ACC_W+1)'(term_p0);
  end

  // Stage 1: accumulator register and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum_p0[ACC_W-1:0];
      ovf <= ovf | sum_p0[ACC_W];
    end
  end

endmodule

// File: rtl/dot_seq.sv
// Vector job sequencer: IDLE/RUN/DONE FSM, beat counter and handshakes
// around the dot_acc datapath. Term selection via macro DOT_SEQ_L1_EN.
module dot_seq
  import kmed_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              overflow,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic              clear;
  logic              beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    beat      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = (len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        beat     = in_valid;
        if (in_valid && cnt == LEN_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Remaining-beat counter, loaded only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (state == ST_IDLE && start) cnt <= len;
    else if (beat)                      cnt <= cnt - LEN_W'(1);
  end

  dot_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (beat),
    .a     (a),
    .b     (b),
    .acc   (out_data),
    .ovf   (overflow)
  );

endmodule
